// File: rtl/pipelined_opcode_decoder_if.sv
// Handshake and decoded-word bundle between fetch, decode and execute.
//   master : fetch/execute side, drives i_inst, i_valid, i_ready and observes the rest
//   slave  : decoder side, consumes i_* and drives o_ready, o_valid, control and fields
interface pipelined_opcode_decoder_if #(
   parameter int unsigned INST_W = 16,
   parameter int unsigned REG_AW = 4,
   parameter int unsigned ALU_W  = 2,
   parameter int unsigned CNT_W  = 16
);
   logic [INST_W-1:0] i_inst;
   logic              i_valid;
   logic              o_ready;
   logic              o_valid;
   logic              i_ready;
   logic              o_jump;
   logic              o_flush;
   logic              o_reg_write;
   logic              o_mem_write;
   logic              o_immediate;
   logic [ALU_W-1:0]  o_alufunc;
   logic [REG_AW-1:0] o_rd;
   logic [REG_AW-1:0] o_rs1;
   logic [REG_AW-1:0] o_rs2;
   logic [REG_AW-1:0] o_imm;
   logic [CNT_W-1:0]  o_stall_cnt;

   modport master (
      output i_inst, i_valid, i_ready,
      input  o_ready, o_valid, o_jump, o_flush, o_reg_write, o_mem_write, o_immediate,
      input  o_alufunc, o_rd, o_rs1, o_rs2, o_imm, o_stall_cnt
   );

   modport slave (
      input  i_inst, i_valid, i_ready,
      output o_ready, o_valid, o_jump, o_flush, o_reg_write, o_mem_write, o_immediate,
      output o_alufunc, o_rd, o_rs1, o_rs2, o_imm, o_stall_cnt
   );
endinterface

// File: rtl/pipelined_opcode_decoder.sv
// Registered instruction-decode stage with valid/ready handshakes, load-use stalling,
// post-jump squashing of wrong-path words and a saturating stall counter.
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of pipelined_opcode_decoder_if (instruction in, decoded word out)
module pipelined_opcode_decoder #(
   parameter int unsigned INST_W    = 16,
   parameter int unsigned OPC_W     = 4,
   parameter int unsigned REG_AW    = 4,
   parameter int unsigned ALU_W     = 2,
   parameter int unsigned FLUSH_CYC = 1,
   parameter int unsigned CNT_W     = 16
) (
   input logic                     clk,
   input logic                     reset,
   pipelined_opcode_decoder_if.slave bus
);

   localparam int unsigned SQ_W = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

   typedef enum logic {StRun, StSquash} state_e;

   state_e            state_q, state_d;
   logic [SQ_W-1:0]   sq_cnt_q, sq_cnt_d;

   // Field extraction of the incoming word
   logic [OPC_W-1:0]  in_opc;
   logic [REG_AW-1:0] in_rd, in_rs1, in_rs2;
   assign in_opc = bus.i_inst[INST_W-1 -: OPC_W];
   assign in_rd  = bus.i_inst[INST_W-OPC_W-1 -: REG_AW];
   assign in_rs1 = bus.i_inst[INST_W-OPC_W-REG_AW-1 -: REG_AW];
   assign in_rs2 = bus.i_inst[REG_AW-1:0];

   logic dec_jump, dec_flush, dec_reg_write, dec_mem_write, dec_immediate, dec_load;

   always_comb begin
      dec_jump      = 1'b0;
      dec_flush     = 1'b0;
      dec_reg_write = 1'b0;
      dec_mem_write = 1'b0;
      dec_immediate = 1'b0;
      dec_load      = 1'b0;
      case (in_opc)
         OPC_W'(0): begin dec_reg_write = 1'b1; dec_immediate = 1'b1; dec_load = 1'b1; end
         OPC_W'(1): begin dec_mem_write = 1'b1; dec_immediate = 1'b1; end
         OPC_W'(2): begin dec_reg_write = 1'b1; dec_immediate = 1'b1; end
         OPC_W'(3): begin dec_jump = 1'b1; dec_flush = 1'b1; end
         OPC_W'(4): begin dec_jump = 1'b1; dec_flush = 1'b1; dec_reg_write = 1'b1; end
         default:   dec_reg_write = 1'b1;
      endcase
   end

   // Stage register S
   logic              valid_q, load_q;
   logic              jump_q, flush_q, reg_write_q, mem_write_q, immediate_q;
   logic [ALU_W-1:0]  alufunc_q;
   logic [REG_AW-1:0] rd_q, rs1_q, rs2_q, imm_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   // A load in S whose rd feeds the incoming word must leave before that word enters
   logic hazard;
   assign hazard = valid_q & load_q & (rd_q != '0) & ((rd_q == in_rs1) | (rd_q == in_rs2)) &
                   bus.i_valid;

   logic ready, load_s, stall_inc;

   always_comb begin
      state_d  = state_q;
      sq_cnt_d = sq_cnt_q;
      ready    = 1'b0;
      load_s   = 1'b0;
      unique case (state_q)
         StRun: begin
            ready = ~hazard & (~valid_q | bus.i_ready);
            if (bus.i_valid && ready) begin
               load_s = 1'b1;
               if (dec_jump && (FLUSH_CYC > 0)) begin
                  state_d  = StSquash;
                  sq_cnt_d = SQ_W'(FLUSH_CYC);
               end
            end
         end
         StSquash: begin
            // Wrong-path words are accepted and dropped; S is left to drain on its own
            ready = 1'b1;
            if (bus.i_valid) begin
               sq_cnt_d = sq_cnt_q - SQ_W'(1);
               if (sq_cnt_q == SQ_W'(1)) state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   assign stall_inc = (state_q == StRun) & hazard;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StRun;
         sq_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         sq_cnt_q <= sq_cnt_d;
         if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q     <= 1'b0;
         load_q      <= 1'b0;
         jump_q      <= 1'b0;
         flush_q     <= 1'b0;
         reg_write_q <= 1'b0;
         mem_write_q <= 1'b0;
         immediate_q <= 1'b0;
         alufunc_q   <= '0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         imm_q       <= '0;
      end else if (load_s) begin
         valid_q     <= 1'b1;
         load_q      <= dec_load;
         jump_q      <= dec_jump;
         flush_q     <= dec_flush;
         reg_write_q <= dec_reg_write;
         mem_write_q <= dec_mem_write;
         immediate_q <= dec_immediate;
         alufunc_q   <= in_opc[ALU_W-1:0];
         rd_q        <= in_rd;
         rs1_q       <= in_rs1;
         rs2_q       <= in_rs2;
         imm_q       <= bus.i_inst[REG_AW-1:0];
      end else if (valid_q && bus.i_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.o_ready     = ready;
   assign bus.o_valid     = valid_q;
   assign bus.o_jump      = jump_q;
   assign bus.o_flush     = flush_q;
   assign bus.o_reg_write = reg_write_q;
   assign bus.o_mem_write = mem_write_q;
   assign bus.o_immediate = immediate_q;
   assign bus.o_alufunc   = alufunc_q;
   assign bus.o_rd        = rd_q;
   assign bus.o_rs1       = rs1_q;
   assign bus.o_rs2       = rs2_q;
   assign bus.o_imm       = imm_q;
   assign bus.o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipelined_opcode_decoder.sv
// Two decoders share one stimulus stream: dut_a (FLUSH_CYC=1, 16-bit counter) and
// dut_b (FLUSH_CYC=0, 2-bit counter). Each is tracked by its own transaction-level model.
module tb_pipelined_opcode_decoder;
   localparam int NDUT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] inst = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;

   always #5 clk = ~clk;

   pipelined_opcode_decoder_if #(.INST_W(16), .REG_AW(4), .ALU_W(2), .CNT_W(16)) bus_a ();
   pipelined_opcode_decoder_if #(.INST_W(16), .REG_AW(4), .ALU_W(2), .CNT_W(2))  bus_b ();

   assign bus_a.i_inst  = inst;
   assign bus_a.i_valid = in_valid;
   assign bus_a.i_ready = out_ready;
   assign bus_b.i_inst  = inst;
   assign bus_b.i_valid = in_valid;
   assign bus_b.i_ready = out_ready;

   pipelined_opcode_decoder #(
      .INST_W(16), .OPC_W(4), .REG_AW(4), .ALU_W(2), .FLUSH_CYC(1), .CNT_W(16)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   pipelined_opcode_decoder #(
      .INST_W(16), .OPC_W(4), .REG_AW(4), .ALU_W(2), .FLUSH_CYC(0), .CNT_W(2)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   logic [NDUT-1:0] got_ready, got_valid;
   logic [22:0]     got_word [NDUT];
   logic [31:0]     got_cnt  [NDUT];

   assign got_ready[0] = bus_a.o_ready;
   assign got_ready[1] = bus_b.o_ready;
   assign got_valid[0] = bus_a.o_valid;
   assign got_valid[1] = bus_b.o_valid;
   assign got_word[0]  = {bus_a.o_jump, bus_a.o_flush, bus_a.o_reg_write, bus_a.o_mem_write,
                          bus_a.o_immediate, bus_a.o_alufunc, bus_a.o_rd, bus_a.o_rs1,
                          bus_a.o_rs2, bus_a.o_imm};
   assign got_word[1]  = {bus_b.o_jump, bus_b.o_flush, bus_b.o_reg_write, bus_b.o_mem_write,
                          bus_b.o_immediate, bus_b.o_alufunc, bus_b.o_rd, bus_b.o_rs1,
                          bus_b.o_rs2, bus_b.o_imm};
   assign got_cnt[0]   = 32'(bus_a.o_stall_cnt);
   assign got_cnt[1]   = 32'(bus_b.o_stall_cnt);

   // Reference model state per DUT
   logic        m_sv  [NDUT];
   logic [15:0] m_s   [NDUT];
   int          m_sq  [NDUT];
   int          m_cnt [NDUT];
   int          flush_cyc [NDUT];
   int          cnt_max   [NDUT];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected decoded word {jump, flush, reg_write, mem_write, immediate, alufunc, rd, rs1, rs2, imm}
   function automatic logic [22:0] exp_word(input logic [15:0] w);
      int   op;
      logic j, f, rw, mw, im;
      op = int'(w >> 12);
      j = 0; f = 0; rw = 0; mw = 0; im = 0;
      if (op == 0)      begin rw = 1; im = 1; end
      else if (op == 1) begin mw = 1; im = 1; end
      else if (op == 2) begin rw = 1; im = 1; end
      else if (op == 3) begin j = 1; f = 1; end
      else if (op == 4) begin j = 1; f = 1; rw = 1; end
      else              rw = 1;
      return {j, f, rw, mw, im, 2'(op % 4), 4'((w >> 8) % 16), 4'((w >> 4) % 16),
              4'(w % 16), 4'(w % 16)};
   endfunction

   function automatic logic model_hazard(input int k, input logic [15:0] w, input logic v);
      int rd;
      rd = int'((m_s[k] >> 8) % 16);
      return v && m_sv[k] && ((m_s[k] >> 12) == 0) && rd != 0 &&
             (rd == int'((w >> 4) % 16) || rd == int'(w % 16));
   endfunction

   function automatic logic model_ready(input int k, input logic [15:0] w, input logic v,
                                        input logic r);
      if (m_sq[k] > 0) return 1'b1;
      return !model_hazard(k, w, v) && (!m_sv[k] || r);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NDUT; k++) begin
         m_sv[k] = 1'b0; m_s[k] = '0; m_sq[k] = 0; m_cnt[k] = 0;
      end
   endtask

   // One clock of stimulus: drive, check against the model, then advance the model
   task automatic step(input logic [15:0] w, input logic v, input logic r);
      @(negedge clk);
      inst = w; in_valid = v; out_ready = r;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         string nm;
         logic  haz, rdy, in_x, out_x;
         int    op;
         nm    = (k == 0) ? "a" : "b";
         haz   = model_hazard(k, w, v);
         rdy   = model_ready(k, w, v, r);
         check({nm, ".ready"}, 32'(got_ready[k]), 32'(rdy));
         check({nm, ".valid"}, 32'(got_valid[k]), 32'(m_sv[k]));
         if (m_sv[k]) check({nm, ".word"}, 32'(got_word[k]), 32'(exp_word(m_s[k])));
         check({nm, ".stall_cnt"}, got_cnt[k], 32'(m_cnt[k]));
         if (m_sq[k] == 0 && haz && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
         in_x  = v && rdy;
         out_x = m_sv[k] && r;
         op    = int'(w >> 12);
         if (in_x && m_sq[k] > 0) begin
            m_sq[k]--;
            if (out_x) m_sv[k] = 1'b0;
         end else if (in_x) begin
            m_s[k]  = w;
            m_sv[k] = 1'b1;
            if (op == 3 || op == 4) m_sq[k] = flush_cyc[k];
         end else if (out_x) begin
            m_sv[k] = 1'b0;
         end
      end
   endtask

   // Hold a word valid until dut_a's model accepts it (bounded)
   task automatic send(input logic [15:0] w, input logic r);
      for (int n = 0; n < 20; n++) begin
         logic acc;
         acc = model_ready(0, w, 1'b1, r);
         step(w, 1'b1, r);
         if (acc) return;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         check("rst.valid", 32'(got_valid[k]), 32'd0);
         check("rst.word", 32'(got_word[k]), 32'd0);
         check("rst.stall_cnt", got_cnt[k], 32'd0);
      end
      model_reset();
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      flush_cyc[0] = 1; flush_cyc[1] = 0;
      cnt_max[0]   = 65535; cnt_max[1] = 3;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      step(16'h0000, 1'b0, 1'b1);

      // Decode sweep, back-to-back
      for (int op = 0; op < 16; op++) step({4'(op), 4'h0, 4'h1, 4'h2}, 1'b1, 1'b1);
      repeat (2) step(16'h0000, 1'b0, 1'b1);

      // Load-use on r3, then the same shape with r0
      send(16'h0312, 1'b1);
      send(16'h5431, 1'b1);
      send(16'h0012, 1'b1);
      send(16'h5401, 1'b1);
      repeat (2) step(16'h0000, 1'b0, 1'b1);

      // Backpressure with S full
      send(16'h6123, 1'b1);
      repeat (3) step(16'h7456, 1'b1, 1'b0);
      step(16'h7456, 1'b1, 1'b1);
      step(16'h8789, 1'b1, 1'b1);
      step(16'h0000, 1'b0, 1'b1);

      // Jump followed by two words
      send(16'h3000, 1'b1);
      send(16'h5111, 1'b1);
      send(16'h6222, 1'b1);
      repeat (3) step(16'h0000, 1'b0, 1'b1);

      // Counter saturation: 6 stalled cycles behind a held load
      send(16'h0312, 1'b1);
      repeat (6) step(16'h5431, 1'b1, 1'b0);
      repeat (3) step(16'h5431, 1'b1, 1'b1);
      step(16'h0000, 1'b0, 1'b1);

      // Reset with a word held in S
      step(16'h9abc, 1'b1, 1'b0);
      do_reset();
      step(16'h0000, 1'b0, 1'b1);

      // Randomised traffic with small register indices to provoke hazards
      for (int i = 0; i < 500; i++) begin
         logic [15:0] w;
         w = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 3))};
         step(w, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
